// File: rtl/keypad_if.sv
// Keypad encoder bus: raw key lines in, BCD code out on a valid/ready handshake.
interface keypad_if;
    logic [0:9] s;
    logic       ready;
    logic [3:0] c;
    logic       valid;
    logic       multi;

    modport master (output s, output ready, input c, input valid, input multi);
    modport slave  (input s, input ready, output c, output valid, output multi);
endinterface

// File: rtl/keypad_encoder.sv
// Decimal keypad front end: synchronises and debounces ten key lines, emits one
// BCD code per clean press and flags simultaneous multi-key presses.
module keypad_encoder #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned CW       = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    keypad_if.slave  kp
);

    typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_OUTPUT, S_RELEASE} state_t;

    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [0:9]    sync1, ks;
    logic [0:9]    snap, snap_nxt;
    logic [3:0]    c_q, c_nxt;
    logic          valid_q, valid_nxt;
    logic          multi_q, multi_nxt;
    logic [3:0]    snap_idx;
    logic          snap_onehot;

    // Two-flop synchroniser for the asynchronous key lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            ks    <= '0;
        end else begin
            sync1 <= kp.s;
            ks    <= sync1;
        end
    end

    // Key index of the snapshot, meaningful only when exactly one bit is set
    always_comb begin
        snap_idx = 4'd0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (snap[i]) snap_idx = 4'(i);
        end
    end

    assign snap_onehot = $onehot(snap);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            snap    <= '0;
            c_q     <= 4'd0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            snap    <= snap_nxt;
            c_q     <= c_nxt;
            valid_q <= valid_nxt;
            multi_q <= multi_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        snap_nxt  = snap;
        c_nxt     = c_q;
        valid_nxt = valid_q;
        multi_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                if (ks != '0) begin
                    state_nxt = S_DEBOUNCE;
                    snap_nxt  = ks;
                    cnt_nxt   = CW'(1);
                end
            end
            S_DEBOUNCE: begin
                if (ks != snap) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt < CNT_DONE) begin
                    cnt_nxt = cnt + CW'(1);
                end else if (snap_onehot) begin
                    state_nxt = S_OUTPUT;
                    c_nxt     = snap_idx;
                    valid_nxt = 1'b1;
                end else begin
                    state_nxt = S_RELEASE;
                    multi_nxt = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            S_OUTPUT: begin
                // Key activity is ignored until the consumer takes the code
                if (valid_q && kp.ready) begin
                    state_nxt = S_RELEASE;
                    valid_nxt = 1'b0;
                    cnt_nxt   = '0;
                end
            end
            S_RELEASE: begin
                if (ks != '0) begin
                    cnt_nxt = '0;
                end else if (cnt >= CNT_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign kp.c     = c_q;
    assign kp.valid = valid_q;
    assign kp.multi = multi_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench for keypad_encoder: directed scenarios plus random key
// traffic, every cycle compared against a run-length reference model.
module tb_keypad_encoder;

    localparam int unsigned DB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keypad_if kp ();

    keypad_encoder #(.DEBOUNCE(DB), .CW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference model: watch (0), code pending (1), locked until quiet (2)
    int         m_mode;
    logic [0:9] sd1, sd2, run_pat;
    int         run_len, zeros, m_c;
    bit         m_valid, m_multi;

    int xfers, multis, edge_idx, first_valid_edge;

    function automatic int popc(input logic [0:9] v);
        int n = 0;
        for (int i = 0; i < 10; i++) if (v[i]) n++;
        return n;
    endfunction

    function automatic int key_of(input logic [0:9] v);
        int k = 0;
        for (int i = 0; i < 10; i++) if (v[i]) k = i;
        return k;
    endfunction

    function automatic logic [0:9] key(input int k);
        logic [0:9] v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_mode = 0; sd1 = '0; sd2 = '0; run_pat = '0;
        run_len = 0; zeros = 0; m_c = 0; m_valid = 0; m_multi = 0;
    endtask

    task automatic model_step(input logic [0:9] sv, input bit rv);
        logic [0:9] x;
        x = sd2;
        sd2 = sd1;
        sd1 = sv;
        m_multi = 0;
        case (m_mode)
            0: begin
                if (x == '0) run_len = 0;
                else if (run_len > 0 && x == run_pat) run_len++;
                else begin run_pat = x; run_len = 1; end
                if (run_len == int'(DB) + 1) begin
                    run_len = 0;
                    zeros = 0;
                    if (popc(x) == 1) begin m_mode = 1; m_c = key_of(x); m_valid = 1; end
                    else begin m_mode = 2; m_multi = 1; end
                end
            end
            1: if (rv) begin m_mode = 2; m_valid = 0; zeros = 0; end
            default: begin
                if (x == '0) zeros++;
                else zeros = 0;
                if (zeros == int'(DB)) begin m_mode = 0; run_len = 0; end
            end
        endcase
    endtask

    // One clock: drive inputs, advance the edge, compare against the model
    task automatic cyc(input logic [0:9] sv, input bit rv, input string tag);
        bit dv;
        kp.s = sv;
        kp.ready = rv;
        dv = kp.valid;
        @(posedge clk);
        #1;
        model_step(sv, rv);
        if (dv && rv) xfers++;
        if (kp.multi) multis++;
        if (kp.valid && !dv && first_valid_edge < 0) first_valid_edge = edge_idx;
        edge_idx++;
        check({tag, ".valid"}, int'(kp.valid), int'(m_valid));
        check({tag, ".multi"}, int'(kp.multi), int'(m_multi));
        check({tag, ".c"}, int'(kp.c), m_c);
    endtask

    task automatic hold(input logic [0:9] sv, input bit rv, input int n, input string tag);
        repeat (n) cyc(sv, rv, tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        kp.s = '0;
        kp.ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", int'(kp.valid), 0);
        check("rst.multi", int'(kp.multi), 0);
        check("rst.c", int'(kp.c), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [0:9] pat;
        int k1, k2, len;

        // 1: clean press of key 7, valid after edge DB+2, one transfer only
        do_reset();
        xfers = 0; edge_idx = 0; first_valid_edge = -1;
        hold(key(7), 1'b1, 20, "t1.hold");
        hold('0, 1'b1, 8, "t1.rel");
        check("t1.lat", first_valid_edge, int'(DB) + 2);
        check("t1.xfers", xfers, 1);
        check("t1.code", int'(kp.c), 7);

        // 2: bouncing key 3 then stable
        xfers = 0;
        for (int i = 0; i < 5; i++) hold((i % 2 == 0) ? key(3) : 10'b0, 1'b1, 2, "t2.bounce");
        hold(key(3), 1'b1, 12, "t2.hold");
        hold('0, 1'b1, 8, "t2.rel");
        check("t2.xfers", xfers, 1);
        check("t2.code", int'(kp.c), 3);

        // 3: consumer stalls, code must be held across key release
        xfers = 0;
        hold(key(9), 1'b0, 8, "t3.press");
        hold('0, 1'b0, 4, "t3.stall");
        check("t3.held_valid", int'(kp.valid), 1);
        check("t3.held_code", int'(kp.c), 9);
        cyc('0, 1'b1, "t3.take");
        check("t3.after_take", int'(kp.valid), 0);
        hold('0, 1'b1, 8, "t3.idle");
        check("t3.xfers", xfers, 1);

        // 4: two keys together are rejected, later single key accepted
        xfers = 0; multis = 0;
        hold(key(2) | key(5), 1'b1, 10, "t4.multi");
        hold('0, 1'b1, 8, "t4.rel");
        hold(key(4), 1'b1, 8, "t4.press");
        hold('0, 1'b1, 8, "t4.rel2");
        check("t4.multis", multis, 1);
        check("t4.xfers", xfers, 1);
        check("t4.code", int'(kp.c), 4);

        // 5: key 0, then reset while key 6 is pending
        xfers = 0;
        hold(key(0), 1'b1, 8, "t5.press0");
        hold('0, 1'b1, 8, "t5.rel0");
        hold(key(6), 1'b0, 8, "t5.press6");
        check("t5.pend_valid", int'(kp.valid), 1);
        check("t5.pend_code", int'(kp.c), 6);
        kp.s = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t5.rst_valid", int'(kp.valid), 0);
        check("t5.rst_code", int'(kp.c), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold('0, 1'b1, 10, "t5.after");
        check("t5.xfers", xfers, 1);

        // 6: short release must not re-arm, full release does
        xfers = 0;
        hold(key(1), 1'b1, 8, "t6.press");
        hold('0, 1'b1, 2, "t6.gap");
        hold(key(1), 1'b1, 6, "t6.repress");
        hold('0, 1'b1, 8, "t6.rel");
        hold(key(1), 1'b1, 8, "t6.press2");
        hold('0, 1'b1, 8, "t6.rel2");
        check("t6.xfers", xfers, 2);
        check("t6.code", int'(kp.c), 1);

        // Random key traffic; nonzero patterns always separated by a quiet gap
        for (int n = 0; n < 250; n++) begin
            k1 = int'($urandom_range(0, 9));
            k2 = (k1 + 1 + int'($urandom_range(0, 8))) % 10;
            case ($urandom_range(0, 2))
                0:       pat = '0;
                1:       pat = key(k1);
                default: pat = key(k1) | key(k2);
            endcase
            len = int'($urandom_range(1, 10));
            for (int i = 0; i < len; i++) cyc(pat, 1'($urandom_range(0, 1)), "rnd.key");
            len = int'($urandom_range(1, 8));
            for (int i = 0; i < len; i++) cyc('0, 1'($urandom_range(0, 1)), "rnd.gap");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
